// File: rtl/inst_fetch.sv
// Instruction fetch stage. It keeps at most one memory request in flight and
// uses a one-entry skid buffer for a response that arrives while decode stalls.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic [31:0] inst,
  output logic [31:0] pcOut,
  output logic        instValid
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              discard_q, discard_d;
  logic [XLEN-1:0]   buf_inst_q, buf_inst_d;
  logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic              inst_valid_q, inst_valid_d;
  logic              loaded;
  logic [XLEN-1:0]   seq_pc;

  // The address after the request is 32-bit modulo, so it wraps at the top of memory.
  assign seq_pc = req_pc_q + PC_STEP;

  // A request is issued only from REQ, and a redirect in the same cycle suppresses it.
  assign imemReq   = (state_q == ST_REQ) && !redirect;
  assign imemAddr  = pc_q;
  assign inst      = inst_q;
  assign pcOut     = pc_out_q;
  assign instValid = inst_valid_q;

  // Next-state and next-output computation; a redirect overrides a stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    discard_d    = discard_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    inst_valid_d = inst_valid_q;
    loaded       = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        if (redirect) begin
          pc_d = redirectPc;
        end else begin
          req_pc_d = pc_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imemValid) begin
          if (discard_q || redirect) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
            if (redirect) pc_d = redirectPc;
          end else if (!stall || !inst_valid_q) begin
            inst_d       = imemRdata;
            pc_out_d     = req_pc_q;
            inst_valid_d = 1'b1;
            loaded       = 1'b1;
            pc_d         = seq_pc;
            state_d      = ST_REQ;
          end else begin
            buf_inst_d = imemRdata;
            buf_pc_d   = req_pc_q;
            pc_d       = seq_pc;
            state_d    = ST_FULL;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
          pc_d      = redirectPc;
        end
      end
      ST_FULL: begin
        if (redirect) begin
          pc_d    = redirectPc;
          state_d = ST_REQ;
        end else if (!stall) begin
          inst_d       = buf_inst_q;
          pc_out_d     = buf_pc_q;
          inst_valid_d = 1'b1;
          loaded       = 1'b1;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (redirect) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end else if (!stall && !loaded) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      discard_q    <= 1'b0;
      buf_inst_q   <= NOP_INST;
      buf_pc_q     <= '0;
      inst_q       <= NOP_INST;
      pc_out_q     <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      discard_q    <= discard_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction presented when no valid instruction is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  downstream cannot accept; hold inst/pcOut/instValid.
REQ-006 redirect  input  1  branch/jump taken; flush and refetch from redirectPc.
REQ-007 redirectPc  input  32  redirect target, word-aligned.
REQ-008 imemReq  output  1  fetch request; accepted by memory on the clk edge where high.
REQ-009 imemAddr  output  32  fetch address, valid while imemReq high.
REQ-010 imemValid  input  1  response strobe, one or more cycles after acceptance.
REQ-011 imemRdata  input  32  instruction word, valid with imemValid.
REQ-012 inst  output  32  registered instruction to the register/decode stage.
REQ-013 pcOut  output  32  registered address of inst.
REQ-014 instValid  output  1  inst/pcOut hold a real fetched instruction.

Function
REQ-015 The block SHALL keep at most one outstanding memory request.
REQ-016 The block SHALL implement states REQ, WAIT and FULL, plus internal registers pc, reqPc, discard, bufInst, bufPc.
REQ-017 imemReq SHALL be 1 only in REQ with redirect low; imemAddr SHALL equal pc.
REQ-018 REQ, redirect low: reqPc<=pc, go WAIT. REQ, redirect high: pc<=redirectPc, stay REQ.
REQ-019 WAIT, imemValid low, redirect high: discard<=1, pc<=redirectPc, stay WAIT.
REQ-020 WAIT, imemValid high with discard or redirect set: drop response, discard<=0, go REQ (pc<=redirectPc if redirect).
REQ-021 WAIT, imemValid high, kept, output free (stall low or instValid low): inst<=imemRdata, pcOut<=reqPc, instValid<=1, pc<=reqPc+4, go REQ.
REQ-022 WAIT, imemValid high, kept, output held (stall high and instValid high): bufInst<=imemRdata, bufPc<=reqPc, pc<=reqPc+4, go FULL.
REQ-023 FULL, stall low, redirect low: inst<=bufInst, pcOut<=bufPc, instValid<=1, go REQ.
REQ-024 FULL, redirect high: drop buffer, pc<=redirectPc, go REQ.
REQ-025 Redirect SHALL override stall: inst<=NOP_INST, instValid<=0, pcOut unchanged, same edge.
REQ-026 When stall low, no redirect and no new instruction loaded: inst<=NOP_INST, instValid<=0.
REQ-027 When stall high and no redirect: inst, pcOut, instValid SHALL hold.
REQ-028 pc+4 SHALL be 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-029 Fetch-to-output latency SHALL be one cycle after imemValid; back-to-back throughput with 1-cycle memory is one instruction per two cycles.

Reset
REQ-030 On rst low, asynchronously: state=REQ, pc=RESET_PC, reqPc=0, discard=0, bufInst=NOP_INST, bufPc=0, inst=NOP_INST, pcOut=0, instValid=0.
REQ-031 Reset asserted mid-request SHALL discard the in-flight request; a response arriving after release while in REQ SHALL be ignored.
REQ-032 First imemReq SHALL assert in the first cycle after rst deasserts, imemAddr=RESET_PC.

Verification
REQ-033 Reset release, 1-cycle memory returning 32'h0050_0093 at 0 -> imemAddr 0, then inst=32'h0050_0093, pcOut=0, instValid=1; next imemAddr=4.
REQ-034 Stall high with instValid=1, response 32'h0010_8113 arrives -> enter FULL, outputs held; stall low -> inst=32'h0010_8113, pcOut=reqPc next edge.
REQ-035 Redirect to 32'h0000_0040 while WAIT, response arrives two cycles later -> response dropped, instValid=0, next imemAddr=32'h40.
REQ-036 Redirect and stall both high with valid output -> inst=NOP_INST, instValid=0 next edge.
REQ-037 RESET_PC=32'hFFFF_FFFC, one fetch -> pcOut=32'hFFFF_FFFC, next imemAddr=32'h0000_0000.
REQ-038 rst pulsed low in WAIT, stale imemValid after release -> ignored; imemAddr=RESET_PC, instValid=0.
